slave_resp_arbiter: RTL and testbench



---
 rtl/slave_resp_arbiter_if.sv | 24 ++
 rtl/slave_resp_arbiter.sv | 143 ++++++++++++++
 tb/tb_slave_resp_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_resp_arbiter_if.sv
// Read-response return path between the slave output ports and the master input port.
// The master modport is the arbiter's view; the slave modport is the surrounding ports' view.
interface slave_resp_arbiter_if #(
    parameter int N_SLAVES = 3
);
    logic                m_ready;
    logic                m_rx_data;
    logic                m_rx_valid;
    logic [N_SLAVES-1:0] s_valid;
    logic [N_SLAVES-1:0] s_ready;
    logic [N_SLAVES-1:0] s_tx_done;
    logic [N_SLAVES-1:0] s_tx_data;
    logic [N_SLAVES-1:0] s_master_ready;

    modport master (
        input  m_ready, s_valid, s_ready, s_tx_done, s_tx_data,
        output m_rx_data, m_rx_valid, s_master_ready
    );

    modport slave (
        output m_ready, s_valid, s_ready, s_tx_done, s_tx_data,
        input  m_rx_data, m_rx_valid, s_master_ready
    );
endinterface

// File: rtl/slave_resp_arbiter.sv
// Round-robin arbiter sharing the serial read-data return line among N slave output ports.
// Optional GRANT-state timeout is enabled by defining SLAVE_RESP_TIMEOUT_EN.
module slave_resp_arbiter #(
    parameter int N_SLAVES    = 3,
    parameter int PTR_W       = 2,
    parameter int DATA_BITS   = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    slave_resp_arbiter_if.master bus,
    output logic [N_SLAVES-1:0]  grant,
    output logic                 busy,
    output logic                 proto_err,
`ifdef SLAVE_RESP_TIMEOUT_EN
    output logic                 timeout_pulse,
`endif
    output logic [1:0]           state_dbg
);
    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [PTR_W-1:0] TOP_IDX  = PTR_W'(N_SLAVES - 1);

    if ((2 ** PTR_W) < N_SLAVES || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("slave_resp_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, XFER = 2'd2} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] g_idx;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand;
    logic             pick_found;
    logic [CNT_W-1:0] bit_cnt;
    logic             err_q;
    logic             valid_g;
    logic             handshake;
    logic             last_bit;
    logic             done_bad;
    logic             timeout_hit;

    // Search upward from rr_ptr+1 with wrap; indices >= N_SLAVES are never visited.
    always_comb begin : pick
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = rr_ptr;
        for (int i = 0; i < N_SLAVES; i++) begin
            cand = (cand == TOP_IDX) ? '0 : cand + 1'b1;
            if (!pick_found && bus.s_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Handshake: a granted slave transfers only when m_ready, its s_valid and its s_ready
    // are all high in the same GRANT cycle; s_master_ready is the grant-gated m_ready.
    assign valid_g            = bus.s_valid[g_idx];
    assign handshake          = (state == GRANT) && bus.m_ready && valid_g && bus.s_ready[g_idx];
    assign last_bit           = (bit_cnt == LAST_BIT);
    assign done_bad           = (state == XFER) && (bus.s_tx_done[g_idx] != last_bit);
    assign bus.s_master_ready = (state == GRANT) ? (grant & {N_SLAVES{bus.m_ready}}) : '0;
    assign bus.m_rx_valid     = (state == XFER);
    assign bus.m_rx_data      = (state == XFER) && bus.s_tx_data[g_idx];
    assign proto_err          = err_q | done_bad;
    assign state_dbg          = state;

`ifdef SLAVE_RESP_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign timeout_hit   = (state == GRANT) && valid_g && !handshake &&
                           (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    assign timeout_pulse = timeout_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            grant   <= '0;
            g_idx   <= '0;
            rr_ptr  <= TOP_IDX;
            bit_cnt <= '0;
            err_q   <= 1'b0;
            busy    <= 1'b0;
`ifdef SLAVE_RESP_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            if (done_bad) err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= GRANT;
                        grant <= N_SLAVES'(1) << pick_idx;
                        g_idx <= pick_idx;
                        busy  <= 1'b1;
`ifdef SLAVE_RESP_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        state   <= XFER;
                        bit_cnt <= '0;
                    end else if (!valid_g || timeout_hit) begin
                        // A withdrawn request keeps its turn; a timed-out one loses it.
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        if (timeout_hit) rr_ptr <= g_idx;
                    end
`ifdef SLAVE_RESP_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                XFER: begin
                    if (last_bit) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        rr_ptr  <= g_idx;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slave_resp_arbiter.sv
// Self-checking bench for slave_resp_arbiter: vector table, directed corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_slave_resp_arbiter;
  localparam int N  = 3;
  localparam int DB = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] grant;
  logic         busy;
  logic         proto_err;
  logic [1:0]   state_dbg;
`ifdef SLAVE_RESP_TIMEOUT_EN
  logic         timeout_pulse;
`endif

  int total = 0;
  int bad   = 0;

  slave_resp_arbiter_if #(.N_SLAVES(N)) bus ();

  slave_resp_arbiter #(.N_SLAVES(N), .PTR_W(2), .DATA_BITS(DB), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.master),
    .grant         (grant),
    .busy          (busy),
    .proto_err     (proto_err),
`ifdef SLAVE_RESP_TIMEOUT_EN
    .timeout_pulse (timeout_pulse),
`endif
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0] valid, ready, done, data;
    logic         mready;
    logic [N-1:0] exp_grant, exp_smr;
    logic         exp_rxv, exp_rxd, exp_busy, exp_err;
  } vec_t;

  vec_t vecs[$];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {grant, bus.s_master_ready, bus.m_rx_valid, bus.m_rx_data, busy, proto_err};
  endfunction

  function automatic logic [9:0] pack(input logic [N-1:0] g, input logic [N-1:0] smr,
                                      input logic rxv, input logic rxd, input logic b,
                                      input logic e);
    return {g, smr, rxv, rxd, b, e};
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r, input logic [N-1:0] d,
                       input logic [N-1:0] x, input logic mr);
    bus.s_valid   = v;
    bus.s_ready   = r;
    bus.s_tx_done = d;
    bus.s_tx_data = x;
    bus.m_ready   = mr;
  endtask

  task automatic wait_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int m_owner, m_last, m_bit, m_wait;
  bit m_xfer, m_err;

  task automatic mdl_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_bit   = 0;
    m_wait  = 0;
    m_xfer  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    drive('0, '0, '0, '0, 1'b0);
    reset = 1'b0;
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mdl_reset();
  endtask

  // Expected outputs for the present cycle, then the model advances by one clock.
  task automatic mdl_step(output logic [9:0] exp_o, output logic exp_to);
    logic [N-1:0] one, g, smr;
    logic viol, hs, to, rxd, found;
    int cand;
    one  = 1;
    g    = (m_owner >= 0) ? (one << m_owner) : '0;
    smr  = (m_owner >= 0 && !m_xfer && bus.m_ready) ? g : '0;
    viol = m_xfer ? (bus.s_tx_done[m_owner] != (m_bit == DB - 1)) : 1'b0;
    rxd  = m_xfer ? bus.s_tx_data[m_owner] : 1'b0;
    hs   = (m_owner >= 0 && !m_xfer) ?
           (bus.m_ready && bus.s_valid[m_owner] && bus.s_ready[m_owner]) : 1'b0;
    to   = 1'b0;
`ifdef SLAVE_RESP_TIMEOUT_EN
    if (m_owner >= 0 && !m_xfer && !hs && bus.s_valid[m_owner] && m_wait == TO - 1) to = 1'b1;
`endif
    exp_o  = pack(g, smr, m_xfer, rxd, m_owner >= 0, m_err || viol);
    exp_to = to;
    m_err  = m_err || viol;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (!found && bus.s_valid[cand]) begin
          found   = 1'b1;
          m_owner = cand;
        end
      end
      m_wait = 0;
    end else if (!m_xfer) begin
      if (hs) begin
        m_xfer = 1'b1;
        m_bit  = 0;
      end else if (!bus.s_valid[m_owner]) begin
        m_owner = -1;
      end else if (to) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_wait++;
      end
    end else if (m_bit == DB - 1) begin
      m_last  = m_owner;
      m_owner = -1;
      m_xfer  = 1'b0;
    end else begin
      m_bit++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]   byte_a5, byte_3c, byte_r, rx;
    logic [N-1:0] v, d, x, r;
    logic [9:0]   exp_o;
    logic         exp_to;
    int           cnt, ph, bk;
    int           order[4];

    byte_a5 = 8'hA5;
    byte_3c = 8'h3C;
    order   = '{0, 1, 2, 0};
    drive('0, '0, '0, '0, 1'b0);

    // Single request from slave 1 carrying A5.
    vecs.push_back('{3'b010, 3'b010, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b010, 3'b010, 3'b000, 3'b000, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int k = 0; k < DB; k++) begin
      vecs.push_back('{3'b000, 3'b010, (k == DB - 1) ? 3'b010 : 3'b000,
                       byte_a5[k] ? 3'b010 : 3'b000, 1'b1,
                       3'b010, 3'b000, 1'b1, byte_a5[k], 1'b1, 1'b0});
    end
    vecs.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});

    do_reset();
    cnt = 0;
    rx  = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].ready, vecs[i].done, vecs[i].data, vecs[i].mready);
      wait_sample();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'(pack(vecs[i].exp_grant, vecs[i].exp_smr, vecs[i].exp_rxv, vecs[i].exp_rxd,
                     vecs[i].exp_busy, vecs[i].exp_err)));
      if (bus.m_rx_valid) begin
        rx  = {bus.m_rx_data, rx[7:1]};
        cnt++;
      end
      next_cycle();
    end
    check("a5_valid_cycles", 32'(cnt), 32'd8);
    check("a5_byte", 32'(rx), 32'hA5);

    // Three continuous requesters, round-robin 0,1,2,0 with one IDLE cycle between frames.
    do_reset();
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      ph = t % 10;
      bk = ph - 2;
      x  = (ph >= 2 && byte_3c[bk[2:0]]) ? 3'b111 : 3'b000;
      d  = (ph == 9) ? 3'b111 : 3'b000;
      drive(3'b111, 3'b111, d, x, 1'b1);
      wait_sample();
      if (ph == 0) begin
        check("rr_idle_gap", 32'({grant, busy, bus.m_rx_valid}), 32'd0);
        cnt = 0;
        rx  = '0;
      end
      if (ph == 1) check($sformatf("rr_grant%0d", t / 10), 32'(grant), 32'(3'b001 << order[t / 10]));
      if (bus.m_rx_valid) begin
        rx = {bus.m_rx_data, rx[7:1]};
        cnt++;
      end
      if (ph == 9) begin
        check($sformatf("rr_bits%0d", t / 10), 32'(cnt), 32'd8);
        check($sformatf("rr_byte%0d", t / 10), 32'(rx), 32'h3C);
        check($sformatf("rr_err%0d", t / 10), 32'(proto_err), 32'd0);
      end
      next_cycle();
    end

    // m_ready held low for 5 GRANT cycles, then released.
    do_reset();
    byte_r = 8'($urandom);
    drive(3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
    wait_sample();
    check("stall_idle", 32'(busy), 32'd0);
    next_cycle();
    for (int t = 1; t <= 5; t++) begin
      wait_sample();
      check($sformatf("stall_grant%0d", t), 32'({bus.s_master_ready, busy, bus.m_rx_valid, grant}),
            32'({3'b000, 1'b1, 1'b0, 3'b001}));
      next_cycle();
    end
    drive(3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
    wait_sample();
    check("stall_release", 32'(bus.s_master_ready), 32'(3'b001));
    next_cycle();
    for (int k = 0; k < DB; k++) begin
      drive(3'b000, 3'b001, (k == DB - 1) ? 3'b001 : 3'b000, byte_r[k] ? 3'b001 : 3'b000, 1'b1);
      wait_sample();
      check($sformatf("stall_bit%0d", k), 32'({bus.m_rx_valid, bus.m_rx_data}), 32'({1'b1, byte_r[k]}));
      next_cycle();
    end
    drive('0, '0, '0, '0, 1'b0);
    wait_sample();
    check("stall_end", 32'({busy, bus.m_rx_valid, proto_err}), 32'd0);
    next_cycle();

    // Early last-bit flag at bit 5 raises a sticky proto_err without cutting the frame short.
    do_reset();
    cnt = 0;
    drive(3'b100, 3'b100, 3'b000, 3'b000, 1'b1);
    wait_sample();
    next_cycle();
    wait_sample();
    check("perr_grant", 32'(grant), 32'(3'b100));
    next_cycle();
    for (int k = 0; k < DB; k++) begin
      d = (k == 5 || k == DB - 1) ? 3'b100 : 3'b000;
      drive(3'b000, 3'b100, d, 3'b000, 1'b1);
      wait_sample();
      check($sformatf("perr_bit%0d", k), 32'(proto_err), 32'(k >= 5));
      if (bus.m_rx_valid) cnt++;
      next_cycle();
    end
    drive('0, '0, '0, '0, 1'b0);
    wait_sample();
    check("perr_sticky", 32'({proto_err, busy, bus.m_rx_valid}), 32'(3'b100));
    check("perr_bits", 32'(cnt), 32'd8);
    next_cycle();

    // Reset asserted during bit 3 clears the outputs without waiting for a clock edge.
    do_reset();
    drive(3'b010, 3'b010, 3'b000, 3'b111, 1'b1);
    next_cycle();
    next_cycle();
    for (int k = 0; k < 3; k++) next_cycle();
    #1;
    check("mid_pre_reset", 32'({bus.m_rx_valid, bus.m_rx_data}), 32'(2'b11));
    reset = 1'b0;
    #1;
    check("mid_async_clear", 32'(outs()), 32'd0);
    check("mid_async_state", 32'(state_dbg), 32'd0);
    next_cycle();
    reset = 1'b1;
    mdl_reset();
    drive(3'b011, 3'b011, 3'b000, 3'b000, 1'b0);
    wait_sample();
    check("mid_after_idle", 32'(grant), 32'd0);
    next_cycle();
    wait_sample();
    check("mid_after_grant", 32'(grant), 32'(3'b001));
    next_cycle();

`ifdef SLAVE_RESP_TIMEOUT_EN
    // Stalled grant to slave 0 times out on its 16th GRANT cycle; slave 2 is next.
    do_reset();
    drive(3'b101, 3'b101, 3'b000, 3'b000, 1'b0);
    wait_sample();
    next_cycle();
    for (int t = 1; t <= TO; t++) begin
      wait_sample();
      check($sformatf("to_pulse%0d", t), 32'({timeout_pulse, grant}), 32'({t == TO, 3'b001}));
      next_cycle();
    end
    wait_sample();
    check("to_idle", 32'({grant, busy, timeout_pulse}), 32'd0);
    next_cycle();
    wait_sample();
    check("to_next_grant", 32'(grant), 32'(3'b100));
    next_cycle();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    v = '0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        v = '0;
      end
      v = v ^ (N'($urandom) & N'($urandom) & N'($urandom));
      r = ~(N'($urandom) & N'($urandom));
      d = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
      x = N'($urandom);
      drive(v, r, d, x, $urandom_range(0, 3) != 0);
      wait_sample();
      mdl_step(exp_o, exp_to);
      check($sformatf("rand_t%0d", t), 32'(outs()), 32'(exp_o));
`ifdef SLAVE_RESP_TIMEOUT_EN
      check($sformatf("rand_to_t%0d", t), 32'(timeout_pulse), 32'(exp_to));
`endif
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
